// File: rtl/nios_multicore_debug_dispatch.sv
// Sysclk-side debug command dispatcher: synchronises vJTAG update strobes, routes the captured
// command word to one or all enabled cores and tracks acks with a timeout. Macro DBG_DISPATCH_STATS_EN
// builds the saturating dispatch/timeout counters.
module nios_multicore_debug_dispatch #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CSW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [IR_WIDTH-1:0]  ir_in,
  input  logic [SR_WIDTH-1:0]  sr,
  input  logic [CSW-1:0]       dbg_core_sel,
  input  logic                 dbg_bcast,
  input  logic [NUM_CORES-1:0] core_en,
  input  logic [NUM_CORES-1:0] core_ack,
  input  logic                 err_clr,
  output logic [SR_WIDTH-1:0]  jdo,
  output logic [IR_WIDTH-1:0]  act_ir,
  output logic                 act_kind,
  output logic [NUM_CORES-1:0] act_valid,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [NUM_CORES-1:0] err_pending,
  output logic                 err_overrun,
  output logic                 err_badsel,
  output logic [15:0]          stat_cmd_cnt,
  output logic [15:0]          stat_to_cnt
);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_ACK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
  logic                   uir_last_q, udr_last_q;
  logic                   uir_pulse_q, udr_pulse_q;
  logic [IR_WIDTH-1:0]    ir_q, ir_d;
  logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]    act_ir_q, act_ir_d;
  logic                   act_kind_q, act_kind_d;
  logic [NUM_CORES-1:0]   tgt_q, tgt_d;
  logic [NUM_CORES-1:0]   ack_seen_q, ack_seen_d;
  logic [15:0]            timer_q, timer_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [NUM_CORES-1:0]   err_pending_q, err_pending_d;
  logic                   err_overrun_q, err_overrun_d;
  logic                   err_badsel_q, err_badsel_d;
  logic [NUM_CORES-1:0]   mask;
  logic [NUM_CORES-1:0]   ack_tgt, acked;
  logic                   to_set, overrun_set, badsel_set;
  logic [NUM_CORES-1:0]   pend_set;

  // Edge pulses are registered once more so the FSM sees them SYNC_STAGES+1 edges after first sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uir_sync_q  <= '0;
      udr_sync_q  <= '0;
      uir_last_q  <= 1'b0;
      udr_last_q  <= 1'b0;
      uir_pulse_q <= 1'b0;
      udr_pulse_q <= 1'b0;
    end else begin
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_last_q  <= uir_sync_q[SYNC_STAGES-1];
      udr_last_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_pulse_q <= uir_sync_q[SYNC_STAGES-1] & ~uir_last_q;
      udr_pulse_q <= udr_sync_q[SYNC_STAGES-1] & ~udr_last_q;
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      mask[i] = core_en[i] & (dbg_bcast | (dbg_core_sel == CSW'(i)));
    end
  end

  assign ack_tgt = core_ack & tgt_q;
  assign acked   = ack_seen_q | ack_tgt;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    jdo_d       = jdo_q;
    act_ir_d    = act_ir_q;
    act_kind_d  = act_kind_q;
    tgt_d       = tgt_q;
    ack_seen_d  = ack_seen_q;
    timer_d     = timer_q;
    to_set      = 1'b0;
    overrun_set = 1'b0;
    badsel_set  = 1'b0;
    pend_set    = '0;

    if (uir_pulse_q) begin
      ir_d = ir_in;
    end

    if (udr_pulse_q) begin
      if (state_q != IDLE) begin
        overrun_set = 1'b1;
      end else if (mask == '0) begin
        badsel_set = 1'b1;
      end else begin
        jdo_d      = sr;
        act_kind_d = sr[SR_WIDTH-1];
        act_ir_d   = ir_q;
        tgt_d      = mask;
        ack_seen_d = '0;
        state_d    = DISPATCH;
      end
    end

    unique case (state_q)
      DISPATCH: begin
        timer_d    = '0;
        ack_seen_d = acked;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        ack_seen_d = acked;
        timer_d    = timer_q + 16'd1;
        if (acked == tgt_q) begin
          state_d = IDLE;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          to_set   = 1'b1;
          pend_set = tgt_q & ~(ack_seen_q | core_ack);
          state_d  = IDLE;
        end
      end
      default: ;
    endcase

    // A set condition beats err_clr in the same cycle.
    err_timeout_d = (err_timeout_q & ~err_clr) | to_set;
    err_pending_d = (err_clr ? '0 : err_pending_q) | pend_set;
    err_overrun_d = (err_overrun_q & ~err_clr) | overrun_set;
    err_badsel_d  = (err_badsel_q & ~err_clr) | badsel_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      jdo_q         <= '0;
      act_ir_q      <= '0;
      act_kind_q    <= 1'b0;
      tgt_q         <= '0;
      ack_seen_q    <= '0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      err_pending_q <= '0;
      err_overrun_q <= 1'b0;
      err_badsel_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      jdo_q         <= jdo_d;
      act_ir_q      <= act_ir_d;
      act_kind_q    <= act_kind_d;
      tgt_q         <= tgt_d;
      ack_seen_q    <= ack_seen_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      err_pending_q <= err_pending_d;
      err_overrun_q <= err_overrun_d;
      err_badsel_q  <= err_badsel_d;
    end
  end

  assign jdo         = jdo_q;
  assign act_ir      = act_ir_q;
  assign act_kind    = act_kind_q;
  assign act_valid   = (state_q == DISPATCH) ? tgt_q : '0;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_timeout_q;
  assign err_pending = err_pending_q;
  assign err_overrun = err_overrun_q;
  assign err_badsel  = err_badsel_q;

`ifdef DBG_DISPATCH_STATS_EN
  logic        dispatch_start;
  logic [15:0] cmd_cnt_q, to_cnt_q;

  assign dispatch_start = (state_q == IDLE) && (state_d == DISPATCH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (dispatch_start && (cmd_cnt_q != '1)) cmd_cnt_q <= cmd_cnt_q + 16'd1;
      if (to_set && (to_cnt_q != '1))          to_cnt_q  <= to_cnt_q + 16'd1;
    end
  end

  assign stat_cmd_cnt = cmd_cnt_q;
  assign stat_to_cnt  = to_cnt_q;
`else
  assign stat_cmd_cnt = '0;
  assign stat_to_cnt  = '0;
`endif

endmodule

// File: tb/tb_nios_multicore_debug_dispatch.sv
// Directed bench for nios_multicore_debug_dispatch; dispatches are checked against a scoreboard queue.
module tb_nios_multicore_debug_dispatch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_uir, vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [1:0]  dbg_core_sel;
  logic        dbg_bcast;
  logic [3:0]  core_en, core_ack;
  logic        err_clr;
  logic [37:0] jdo;
  logic [1:0]  act_ir;
  logic        act_kind;
  logic [3:0]  act_valid;
  logic        busy, err_timeout, err_overrun, err_badsel;
  logic [3:0]  err_pending;
  logic [15:0] stat_cmd_cnt, stat_to_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [37:0] jdo;
    logic [3:0]  av;
    logic        kind;
    logic [1:0]  ir;
  } exp_t;
  exp_t sb[$];

`ifdef DBG_DISPATCH_STATS_EN
  localparam logic [15:0] EXP_CMD = 16'd4;
  localparam logic [15:0] EXP_TO  = 16'd1;
`else
  localparam logic [15:0] EXP_CMD = 16'd0;
  localparam logic [15:0] EXP_TO  = 16'd0;
`endif

  always #5 clk = ~clk;

  nios_multicore_debug_dispatch #(
    .NUM_CORES(4), .SR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(2), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .dbg_core_sel(dbg_core_sel), .dbg_bcast(dbg_bcast), .core_en(core_en), .core_ack(core_ack),
    .err_clr(err_clr), .jdo(jdo), .act_ir(act_ir), .act_kind(act_kind), .act_valid(act_valid),
    .busy(busy), .err_timeout(err_timeout), .err_pending(err_pending), .err_overrun(err_overrun),
    .err_badsel(err_badsel), .stat_cmd_cnt(stat_cmd_cnt), .stat_to_cnt(stat_to_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every dispatch pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && act_valid !== 4'b0000) begin
      chk("sb_underflow", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("disp_act_valid", act_valid, e.av);
        chk("disp_jdo", jdo, e.jdo);
        chk("disp_act_kind", act_kind, e.kind);
        chk("disp_act_ir", act_ir, e.ir);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [37:0] s, input logic [3:0] av, input logic [1:0] ir);
    exp_t e;
    e.jdo  = s;
    e.av   = av;
    e.kind = s[37];
    e.ir   = ir;
    sb.push_back(e);
  endtask

  // Raise vs_udr and advance to the third edge after its first sample.
  task automatic launch();
    vs_udr = 1'b1;
    tick(); tick(); tick();
    chk("pre_dispatch_idle", busy, 1'b0);
    vs_udr = 1'b0;
    tick();
  endtask

  task automatic load_ir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
    dbg_core_sel = '0; dbg_bcast = 1'b0; core_en = '0; core_ack = '0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_jdo", jdo, 38'h0);
    chk("rst_act_valid", act_valid, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errs", {err_timeout, err_pending, err_overrun, err_badsel}, 7'h0);
    chk("rst_act", {act_ir, act_kind}, 3'h0);
    chk("rst_stats", {stat_cmd_cnt, stat_to_cnt}, 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    load_ir(2'b10);
    dbg_core_sel = 2'd2; dbg_bcast = 1'b0; core_en = 4'hF; sr = 38'h2_0000_1234;
    push_exp(sr, 4'b0100, 2'b10);
    launch();
    chk("c1_jdo", jdo, 38'h2_0000_1234);
    chk("c1_busy", busy, 1'b1);
    chk("c1_act_valid", act_valid, 4'b0100);
    tick();
    chk("c1_act_valid_off", act_valid, 4'b0000);
    chk("c1_busy_wait", busy, 1'b1);
    repeat (3) tick();
    core_ack = 4'b0100;
    tick();
    core_ack = 4'b0000;
    chk("c1_done", busy, 1'b0);
    chk("c1_errs", {err_timeout, err_pending, err_overrun, err_badsel}, 7'h0);

    dbg_core_sel = 2'd0; dbg_bcast = 1'b1; core_en = 4'b1011; sr = 38'h1_2345_6789;
    push_exp(sr, 4'b1011, 2'b10);
    launch();
    chk("c2_jdo", jdo, 38'h1_2345_6789);
    tick();
    core_ack = 4'b0001; tick();
    core_ack = 4'b0010; tick();
    core_ack = 4'b0100; tick();
    core_ack = 4'b0000;
    sr = '0;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    tick();
    chk("ovr_flag", err_overrun, 1'b1);
    chk("ovr_jdo_held", jdo, 38'h1_2345_6789);
    chk("ovr_busy", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 248);
    chk("to_flag", err_timeout, 1'b1);
    chk("to_pending", err_pending, 4'b1000);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_errs", {err_timeout, err_pending, err_overrun, err_badsel}, 7'h0);

    dbg_core_sel = 2'd1; dbg_bcast = 1'b0; core_en = 4'b1101; sr = 38'h0_0000_00AA;
    err_clr = 1'b1;
    launch();
    chk("bad_flag", err_badsel, 1'b1);
    chk("bad_busy", busy, 1'b0);
    chk("bad_jdo_held", jdo, 38'h1_2345_6789);
    err_clr = 1'b0; tick();
    chk("bad_sticky", err_badsel, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("bad_cleared", err_badsel, 1'b0);

    load_ir(2'b01);
    dbg_core_sel = 2'd1; core_en = 4'hF; sr = 38'h3F_FFFF_FFFF;
    push_exp(sr, 4'b0010, 2'b01);
    launch();
    core_ack = 4'b0011; tick(); core_ack = 4'b0000;
    chk("c6_busy_wait", busy, 1'b1);
    tick();
    chk("c6_done", busy, 1'b0);
    chk("c6_errs", {err_timeout, err_pending, err_overrun, err_badsel}, 7'h0);

    dbg_core_sel = 2'd3; sr = 38'h0_DEAD_BEEF;
    push_exp(sr, 4'b1000, 2'b01);
    launch();
    core_ack = 4'b1000; tick(); core_ack = 4'b0000;
    tick();
    chk("c7_done", busy, 1'b0);
    chk("stat_cmd", stat_cmd_cnt, EXP_CMD);
    chk("stat_to", stat_to_cnt, EXP_TO);

    dbg_core_sel = 2'd0; sr = 38'h0_0000_0F0F;
    push_exp(sr, 4'b0001, 2'b01);
    launch();
    tick();
    chk("c8_busy_wait", busy, 1'b1);
    reset_n = 1'b0; tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_act_valid", act_valid, 4'h0);
    chk("mid_rst_jdo", jdo, 38'h0);
    chk("mid_rst_errs", {err_timeout, err_pending, err_overrun, err_badsel}, 7'h0);
    chk("mid_rst_stats", {stat_cmd_cnt, stat_to_cnt}, 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
